rand_share_arbiter: RTL

Shares one free-running `random` number source between NREQ requesters. Each requester raises a level request. The block grants requests round-robin, captures the current random value on the grant edge, and returns it with a one-cycle acknowledge. A programmable cooldown after each grant lets the modulo counter advance, so back-to-back consumers never receive the same sample. It sits between the `random` instance and the game/control logic that consumes random numbers.

---
 rtl/rand_share_pkg.sv | 18 +
 rtl/rr_pick.sv | 28 ++
 rtl/rand_share_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/rand_share_pkg.sv
// Shared types and helpers for the random-number sharing arbiter.
// Holds the FSM state encoding, the cooldown bound and the round-robin pointer step.
package rand_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  localparam int GAP_MAX = 15;

  // Next round-robin start position after granting index w out of n requesters.
  function automatic int rr_next(input int w, input int n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            found
);

  logic [IDXW-1:0] sel;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel = IDXW'((int'(ptr) + i) % NREQ);
      if (!found && req[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/rand_share_arbiter.sv
// Shares one free-running random source between NREQ requesters: round-robin
// grant, sample capture on the grant edge, then a GAP-cycle cooldown.
module rand_share_arbiter
  import rand_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MODULUS = 10,
  parameter int NBITS   = $clog2(MODULUS),
  parameter int GAP     = 2,
  parameter int IDXW    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] rnd_in,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [NBITS-1:0] value,
  output logic [IDXW-1:0]  gnt_idx,
  output logic             busy
);

  localparam int CNTW = $clog2(GAP_MAX + 1);
  localparam logic [CNTW-1:0] COOL_LOAD = CNTW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  winner;
  logic             found;
  logic [NREQ-1:0]  ack_d;
  logic [NBITS-1:0] value_d;
  logic [IDXW-1:0]  gnt_d;

  rr_pick #(
    .NREQ(NREQ),
    .IDXW(IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(winner),
    .found (found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack     <= '0;
      value   <= '0;
      gnt_idx <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack     <= ack_d;
      value   <= value_d;
      gnt_idx <= gnt_d;
    end
  end

  // ack is a single-cycle pulse; value and gnt_idx hold until the next grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    value_d = value;
    gnt_d   = gnt_idx;
    case (state_q)
      IDLE: begin
        if (found) begin
          ack_d   = NREQ'(1) << winner;
          value_d = rnd_in;
          gnt_d   = winner;
          ptr_d   = IDXW'(rr_next(int'(winner), NREQ));
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (GAP > 0) begin
          cnt_d   = COOL_LOAD;
          state_d = COOL;
        end else begin
          state_d = IDLE;
        end
      end
      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
